// File: rtl/fetch_decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_decode_unit                                                    |
// | Fetch/decode sequencer: PC/AR/IR, one-level indirection, issue hs.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_decode_unit #(
  parameter int                 ADDR_W   = 4,
  parameter int                 DATA_W   = ADDR_W + 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic              indirect,
  output logic              reg_ref,
  output logic              io_ref,
  output logic [ADDR_W-1:0] eff_addr,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_INDIRECT = 3'd3,
    S_ISSUE    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_ar;
  logic [DATA_W-1:0]   r_ir;
  logic                w_handshake;

  assign w_handshake = (r_state == S_ISSUE) && issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ar    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 1'b1;
        end
        S_DECODE:   r_ar <= r_ir[ADDR_W-1:0];
        S_INDIRECT: r_ar <= mem_rdata[ADDR_W-1:0];
        S_ISSUE:    if (w_handshake && pc_load) r_pc <= pc_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_read     = 1'b0;
    mem_addr     = '0;
    issue_valid  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: begin
        mem_read     = 1'b1;
        mem_addr     = r_pc;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // opcode 7 is a register/IO reference; its I bit never means indirection
        if (r_ir[DATA_W-1] && (r_ir[DATA_W-2:DATA_W-4] != 3'd7))
          w_next_state = S_INDIRECT;
        else
          w_next_state = S_ISSUE;
      end
      S_INDIRECT: begin
        mem_read     = 1'b1;
        mem_addr     = r_ar;
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        if (w_handshake) w_next_state = halt ? S_IDLE : S_FETCH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign ir       = r_ir;
  assign opcode   = r_ir[DATA_W-2:DATA_W-4];
  assign indirect = r_ir[DATA_W-1];
  assign reg_ref  = (opcode == 3'd7) && !indirect;
  assign io_ref   = (opcode == 3'd7) && indirect;
  assign eff_addr = r_ar;
  assign pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_decode_unit                                                 |
// | Cycle-by-cycle directed vectors against a behavioural 16x8 RAM.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_decode_unit;

  logic       clk = 1'b0;
  logic       rst, start, halt, issue_ready, pc_load;
  logic [3:0] pc_in;
  logic       mem_read, issue_valid, indirect, reg_ref, io_ref, busy;
  logic [3:0] mem_addr, eff_addr, pc;
  logic [7:0] mem_rdata, ir;
  logic [2:0] opcode;

  logic [7:0] ram [0:15];
  assign mem_rdata = ram[mem_addr];

  always #5 clk = ~clk;

  fetch_decode_unit #(.ADDR_W(4), .DATA_W(8), .RESET_PC(4'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ir(ir), .opcode(opcode), .indirect(indirect), .reg_ref(reg_ref),
    .io_ref(io_ref), .eff_addr(eff_addr), .pc(pc),
    .pc_load(pc_load), .pc_in(pc_in), .busy(busy)
  );

  typedef struct {
    logic       rst, start, rdy, pld, hlt;
    logic [3:0] pin;
    logic       busy, rd, vld;
    logic [3:0] addr;
    logic [7:0] ir;
    logic [2:0] op;
    logic [2:0] flags;   // {indirect, reg_ref, io_ref}
    logic [3:0] eff, pc;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic s, input logic rd_y, input logic pl,
                     input logic [3:0] pi, input logic h,
                     input logic b, input logic rd, input logic [3:0] a, input logic v,
                     input logic [7:0] i, input logic [2:0] o, input logic [2:0] f,
                     input logic [3:0] e, input logic [3:0] p);
    vec_t t;
    t.rst = r; t.start = s; t.rdy = rd_y; t.pld = pl; t.pin = pi; t.hlt = h;
    t.busy = b; t.rd = rd; t.addr = a; t.vld = v; t.ir = i; t.op = o;
    t.flags = f; t.eff = e; t.pc = p;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) ram[k] = 8'h00;
    ram[0]  = 8'h0C; ram[1] = 8'h9A; ram[2] = 8'h25; ram[3] = 8'h76;
    ram[4]  = 8'hF6; ram[6] = 8'h03; ram[10] = 8'h1B; ram[15] = 8'h31;

    rst = 1'b1; start = 1'b0; halt = 1'b0; issue_ready = 1'b1;
    pc_load = 1'b0; pc_in = 4'h0;

    //   rst st rdy pld pin hlt | busy rd addr vld ir     op flags   eff   pc
    add(1, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h00, 0, 3'b000, 4'h0, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h00, 0, 3'b000, 4'h0, 4'h0);
    add(0, 1, 1, 0, 4'h0, 0,   1, 1, 4'h0, 0, 8'h00, 0, 3'b000, 4'h0, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h0C, 0, 3'b000, 4'h0, 4'h1);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h0C, 0, 3'b000, 4'hC, 4'h1);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'h1, 0, 8'h0C, 0, 3'b000, 4'hC, 4'h1);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h9A, 1, 3'b100, 4'hC, 4'h2);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'hA, 0, 8'h9A, 1, 3'b100, 4'hA, 4'h2);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h9A, 1, 3'b100, 4'hB, 4'h2);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'h2, 0, 8'h9A, 1, 3'b100, 4'hB, 4'h2);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h25, 2, 3'b000, 4'hB, 4'h3);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h25, 2, 3'b000, 4'h5, 4'h3);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'h3, 0, 8'h25, 2, 3'b000, 4'h5, 4'h3);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h76, 7, 3'b010, 4'h5, 4'h4);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h76, 7, 3'b010, 4'h6, 4'h4);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'h4, 0, 8'h76, 7, 3'b010, 4'h6, 4'h4);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'hF6, 7, 3'b101, 4'h6, 4'h5);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'hF6, 7, 3'b101, 4'h6, 4'h5);
    // ready low: start, pc_load and halt must all be ignored
    for (int k = 0; k < 3; k++)
      add(0, 1, 0, 1, 4'h3, 1, 1, 0, 4'h0, 1, 8'hF6, 7, 3'b101, 4'h6, 4'h5);
    add(0, 0, 1, 1, 4'hF, 0,   1, 1, 4'hF, 0, 8'hF6, 7, 3'b101, 4'h6, 4'hF);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h31, 3, 3'b000, 4'h6, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h31, 3, 3'b000, 4'h1, 4'h0);
    add(0, 0, 1, 0, 4'h0, 1,   0, 0, 4'h0, 0, 8'h31, 3, 3'b000, 4'h1, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h31, 3, 3'b000, 4'h1, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h31, 3, 3'b000, 4'h1, 4'h0);
    add(0, 1, 1, 0, 4'h0, 0,   1, 1, 4'h0, 0, 8'h31, 3, 3'b000, 4'h1, 4'h0);
    add(0, 1, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h0C, 0, 3'b000, 4'h1, 4'h1);
    add(0, 1, 1, 0, 4'h0, 0,   1, 0, 4'h0, 1, 8'h0C, 0, 3'b000, 4'hC, 4'h1);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'h1, 0, 8'h0C, 0, 3'b000, 4'hC, 4'h1);
    add(0, 0, 1, 0, 4'h0, 0,   1, 0, 4'h0, 0, 8'h9A, 1, 3'b100, 4'hC, 4'h2);
    add(0, 0, 1, 0, 4'h0, 0,   1, 1, 4'hA, 0, 8'h9A, 1, 3'b100, 4'hA, 4'h2);
    add(1, 1, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h00, 0, 3'b000, 4'h0, 4'h0);
    add(0, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'h00, 0, 3'b000, 4'h0, 4'h0);

    for (int r = 0; r < vecs.size(); r++) begin
      rst = vecs[r].rst; start = vecs[r].start; issue_ready = vecs[r].rdy;
      pc_load = vecs[r].pld; pc_in = vecs[r].pin; halt = vecs[r].hlt;
      tick();
      chk($sformatf("row%0d", r),
          {3'b0, busy, mem_read, mem_addr, issue_valid, ir, opcode,
           indirect, reg_ref, io_ref, eff_addr, pc},
          {3'b0, vecs[r].busy, vecs[r].rd, vecs[r].addr, vecs[r].vld, vecs[r].ir,
           vecs[r].op, vecs[r].flags, vecs[r].eff, vecs[r].pc});
    end

    // bounded latency check from FETCH, then reset while stalled in ISSUE
    rst = 1'b0; pc_load = 1'b0; halt = 1'b0; issue_ready = 1'b0; start = 1'b1;
    tick();
    chk("lat_fetch", {mem_read, mem_addr}, {1'b1, 4'h0});
    start = 1'b0;
    n = 0;
    while (!issue_valid && n < 8) begin
      tick();
      n++;
    end
    chk("lat_cycles", n, 2);
    tick(); tick();
    chk("stall_hold", {issue_valid, mem_read, eff_addr, pc, ir},
        {1'b1, 1'b0, 4'hC, 4'h1, 8'h0C});
    rst = 1'b1;
    tick();
    chk("rst_in_issue", {busy, issue_valid, mem_read, pc, ir, eff_addr},
        {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0});
    rst = 1'b0;
    tick();
    chk("idle_after_rst", {busy, mem_read}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Instruction fetch/decode sequencer that sits directly upstream of the 16x8 program/data RAM and drives its read/addr inputs.
- Holds PC, AR and IR, fetches 8-bit instructions, and splits each into I bit, 3-bit opcode and 4-bit address.
- Resolves one level of indirect addressing through the same RAM.
- Hands the decoded instruction to the execute stage over a valid/ready handshake; accepts branch PC loads back from it.

Parameters:
- ADDR_W, 4, address width; PC/AR/eff_addr width; RAM depth is 2**ADDR_W.
- DATA_W, 8, instruction/RAM word width; fixed at ADDR_W+4 (I bit, 3-bit opcode, address field).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching at current PC.
- halt  input  1  return to IDLE after the current issue handshake.
- mem_read  output  1  RAM read strobe.
- mem_addr  output  ADDR_W  RAM address (PC in FETCH, AR in INDIRECT, else 0).
- mem_rdata  input  DATA_W  RAM read data; combinational from mem_addr, sampled at end of the same cycle.
- issue_valid  output  1  decoded instruction available.
- issue_ready  input  1  execute stage accepts the instruction.
- ir  output  DATA_W  fetched instruction word.
- opcode  output  3  IR[6:4].
- indirect  output  1  IR[7].
- reg_ref  output  1  opcode==7 and I==0.
- io_ref  output  1  opcode==7 and I==1.
- eff_addr  output  ADDR_W  effective address (AR).
- pc  output  ADDR_W  current PC (already incremented past the issued instruction).
- pc_load  input  1  replace PC with pc_in at the issue handshake.
- pc_in  input  ADDR_W  branch target.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, FETCH, DECODE, INDIRECT, ISSUE. mem_read, mem_addr, issue_valid and busy are decoded from state (Moore outputs).
- Reset (rst=1 at an edge, any state, including mid-INDIRECT or mid-ISSUE):
  - state=IDLE, PC=RESET_PC, AR=0, IR=0.
  - All outputs 0 except pc=RESET_PC.
- IDLE:
  - start=1 -> FETCH.
  - start is ignored in every other state.
- FETCH (mem_read=1, mem_addr=PC):
  - IR<=mem_rdata; PC<=PC+1 modulo 2**ADDR_W (15 -> 0).
  - Next state DECODE.
- DECODE (no memory access):
  - AR<=IR[3:0].
  - If IR[7]=1 and opcode!=7 -> INDIRECT, else -> ISSUE.
  - Opcode 7 never triggers indirection.
- INDIRECT (mem_read=1, mem_addr=AR):
  - AR<=mem_rdata[3:0]. Exactly one level of indirection.
  - Next state ISSUE.
- ISSUE (issue_valid=1):
  - ir/opcode/indirect/reg_ref/io_ref/eff_addr stay stable while waiting.
  - Handshake = issue_valid & issue_ready at an edge.
  - On handshake: if pc_load=1, PC<=pc_in. If halt=1 -> IDLE, else -> FETCH.
  - pc_load and halt are ignored outside the handshake edge. Simultaneous pc_load+halt applies both.
- Latency from entering FETCH to issue_valid: 2 cycles direct, 3 cycles indirect.
- Minimum 3 cycles per instruction direct, 4 indirect, with issue_ready held at 1.
- mem_read is never asserted in IDLE, DECODE or ISSUE. The block never writes memory.

Test Plan:
- RAM[0]=0x0C; rst, then start pulse -> FETCH/DECODE/ISSUE; issue_valid 2 cycles after FETCH; opcode=0, indirect=0, eff_addr=0xC, pc=1, reg_ref=0.
- RAM[1]=0x9A, RAM[0xA]=0x1B, PC=1 -> INDIRECT cycle shows mem_addr=0xA; issue with opcode=1, indirect=1, eff_addr=0xB, pc=2.
- RAM[3]=0x76 then RAM[4]=0xF6 -> first: reg_ref=1, eff_addr=6, no INDIRECT. Second: io_ref=1, indirect=1, no INDIRECT cycle, eff_addr=6.
- issue_ready low 3 cycles in ISSUE -> outputs stable, no mem_read. Then ready with pc_load=1, pc_in=0xF -> next FETCH mem_addr=0xF; after that fetch pc=0 (wrap).
- halt=1 at handshake -> IDLE, busy=0, no further mem_read. start -> resumes at current PC.
- rst asserted during INDIRECT -> next cycle IDLE, pc=0, issue_valid=0, mem_read=0. Start ignored while busy.
